// File: rtl/conv_pkg.sv
`default_nettype none
// ============================================================================
// conv_pkg : shared types and constants for the convolution window sequencer
// Rev 1.0
// ============================================================================
package conv_pkg;

  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    CHECK = 3'd1,
    ISSUE = 3'd2,
    DRAIN = 3'd3,
    DONE  = 3'd4
  } seq_state_t;

  localparam logic [1:0] STRIDE_MAX = 2'd2;
  localparam logic [3:0] K_MAX      = 4'd15;

  // Descriptor layout at the default DIM_W=16 / ADDR_W=32 widths.
  typedef struct packed {
    logic [15:0] row;
    logic [15:0] col;
    logic [31:0] addr;
    logic        last;
  } win_desc_t;

endpackage
`default_nettype wire

// File: rtl/conv_addr_gen.sv
`default_nettype none
// ============================================================================
// conv_addr_gen : row/col/row_base stepping and last-window detection
// Rev 1.0
// ============================================================================
module conv_addr_gen
  import conv_pkg::*;
#(
  parameter int DIM_W  = 16,
  parameter int ADDR_W = 32
) (
  input  logic              clk_i,
  input  logic              rst_i,
  input  logic              init_i,
  input  logic              step_i,
  input  logic [DIM_W-1:0]  width_i,
  input  logic [DIM_W-1:0]  height_i,
  input  logic [3:0]        ksize_i,
  input  logic [1:0]        stride_i,
  input  logic [ADDR_W-1:0] base_i,
  output logic [DIM_W-1:0]  row_o,
  output logic [DIM_W-1:0]  col_o,
  output logic [ADDR_W-1:0] addr_o,
  output logic              last_o
);

  localparam int DW1 = DIM_W + 1;

  logic [DIM_W-1:0]  row_q, row_d;
  logic [DIM_W-1:0]  col_q, col_d;
  logic [ADDR_W-1:0] rbase_q, rbase_d;
  logic [DIM_W:0]    w_col_lim, w_row_lim, w_col_nxt, w_row_nxt;
  logic [ADDR_W-1:0] w_pitch;
  logic              w_col_wrap, w_row_end;

  // Limits are one extra bit wide so col+S never wraps before the compare.
  always_comb begin
    w_col_lim  = {1'b0, width_i}  - DW1'(ksize_i);
    w_row_lim  = {1'b0, height_i} - DW1'(ksize_i);
    w_col_nxt  = {1'b0, col_q} + DW1'(stride_i);
    w_row_nxt  = {1'b0, row_q} + DW1'(stride_i);
    w_col_wrap = w_col_nxt > w_col_lim;
    w_row_end  = w_row_nxt > w_row_lim;
    w_pitch    = (stride_i == 2'd2) ? (ADDR_W'(width_i) << 1) : ADDR_W'(width_i);
  end

  always_comb begin
    row_d   = row_q;
    col_d   = col_q;
    rbase_d = rbase_q;
    if (init_i) begin
      row_d   = '0;
      col_d   = '0;
      rbase_d = '0;
    end else if (step_i) begin
      if (w_col_wrap) begin
        col_d   = '0;
        row_d   = w_row_nxt[DIM_W-1:0];
        rbase_d = rbase_q + w_pitch;
      end else begin
        col_d = w_col_nxt[DIM_W-1:0];
      end
    end
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      row_q   <= '0;
      col_q   <= '0;
      rbase_q <= '0;
    end else begin
      row_q   <= row_d;
      col_q   <= col_d;
      rbase_q <= rbase_d;
    end
  end

  assign row_o  = row_q;
  assign col_o  = col_q;
  assign addr_o = base_i + rbase_q + ADDR_W'(col_q);
  assign last_o = w_col_wrap & w_row_end;

endmodule
`default_nettype wire

// File: rtl/conv_window_sequencer.sv
`default_nettype none
// ============================================================================
// conv_window_sequencer : issues one window descriptor per output pixel
// Rev 1.0
// ============================================================================
module conv_window_sequencer
  import conv_pkg::*;
#(
  parameter int DIM_W  = 16,
  parameter int ADDR_W = 32,
  parameter int CNT_W  = 32
) (
  input  logic              ACLK,
  input  logic              ARESET,
  input  logic              cfg_start,
  input  logic              cfg_abort,
  input  logic [DIM_W-1:0]  cfg_width,
  input  logic [DIM_W-1:0]  cfg_height,
  input  logic [3:0]        cfg_ksize,
  input  logic [1:0]        cfg_stride,
  input  logic [ADDR_W-1:0] cfg_base_addr,
  output logic              win_valid,
  input  logic              win_ready,
  output logic [DIM_W-1:0]  win_row,
  output logic [DIM_W-1:0]  win_col,
  output logic [ADDR_W-1:0] win_addr,
  output logic              win_last,
  input  logic              res_valid,
  output logic              sts_busy,
  output logic              sts_done,
  output logic              sts_err,
  output logic [CNT_W-1:0]  sts_count,
  output logic              irq
);

  localparam logic [2:0] ST_IDLE  = IDLE;
  localparam logic [2:0] ST_CHECK = CHECK;
  localparam logic [2:0] ST_ISSUE = ISSUE;
  localparam logic [2:0] ST_DRAIN = DRAIN;
  localparam logic [2:0] ST_DONE  = DONE;

  logic [2:0]        state_q, state_d;
  logic [DIM_W-1:0]  width_q, height_q;
  logic [3:0]        ksize_q;
  logic [1:0]        stride_q;
  logic [ADDR_W-1:0] base_q;
  logic [CNT_W-1:0]  issued_q, issued_d;
  logic [CNT_W-1:0]  count_q, count_d;
  logic              err_q, err_d;
  logic              irq_q, irq_d;

  logic w_hs, w_busy, w_cfg_bad, w_cfg_ld, w_ag_init, w_ag_last;

  assign w_hs      = (state_q == ST_ISSUE) && win_ready;
  assign w_busy    = (state_q == ST_CHECK) || (state_q == ST_ISSUE) || (state_q == ST_DRAIN);
  assign w_cfg_bad = (ksize_q == 4'd0) || !ksize_q[0] ||
                     (DIM_W'(ksize_q) > width_q) || (DIM_W'(ksize_q) > height_q) ||
                     (stride_q == 2'd0) || (stride_q > STRIDE_MAX);

  always_comb begin
    state_d   = state_q;
    issued_d  = issued_q;
    count_d   = count_q;
    err_d     = err_q;
    irq_d     = 1'b0;
    w_cfg_ld  = 1'b0;
    w_ag_init = 1'b0;
    if (res_valid && (state_q != ST_IDLE)) count_d = count_q + CNT_W'(1);
    if (w_hs) issued_d = issued_q + CNT_W'(1);
    // Abort outranks everything, including a coincident start.
    if (cfg_abort && w_busy) begin
      state_d = ST_IDLE;
      err_d   = 1'b1;
      irq_d   = 1'b1;
    end else begin
      case (state_q)
        ST_IDLE, ST_DONE: begin
          if (cfg_start && !cfg_abort) begin
            state_d  = ST_CHECK;
            err_d    = 1'b0;
            count_d  = '0;
            issued_d = '0;
            w_cfg_ld = 1'b1;
          end
        end
        ST_CHECK: begin
          if (w_cfg_bad) begin
            state_d = ST_IDLE;
            err_d   = 1'b1;
            irq_d   = 1'b1;
          end else begin
            state_d   = ST_ISSUE;
            w_ag_init = 1'b1;
          end
        end
        ST_ISSUE: if (w_hs && w_ag_last) state_d = ST_DRAIN;
        ST_DRAIN: begin
          if (count_q == issued_q) begin
            state_d = ST_DONE;
            irq_d   = 1'b1;
          end
        end
        default: state_d = ST_IDLE;
      endcase
    end
  end

  always_ff @(posedge ACLK or posedge ARESET) begin
    if (ARESET) begin
      state_q  <= ST_IDLE;
      width_q  <= '0;
      height_q <= '0;
      ksize_q  <= '0;
      stride_q <= '0;
      base_q   <= '0;
      issued_q <= '0;
      count_q  <= '0;
      err_q    <= 1'b0;
      irq_q    <= 1'b0;
    end else begin
      state_q  <= state_d;
      issued_q <= issued_d;
      count_q  <= count_d;
      err_q    <= err_d;
      irq_q    <= irq_d;
      if (w_cfg_ld) begin
        width_q  <= cfg_width;
        height_q <= cfg_height;
        ksize_q  <= cfg_ksize;
        stride_q <= cfg_stride;
        base_q   <= cfg_base_addr;
      end
    end
  end

  conv_addr_gen #(
    .DIM_W  (DIM_W),
    .ADDR_W (ADDR_W)
  ) u_addr_gen (
    .clk_i    (ACLK),
    .rst_i    (ARESET),
    .init_i   (w_ag_init),
    .step_i   (w_hs),
    .width_i  (width_q),
    .height_i (height_q),
    .ksize_i  (ksize_q),
    .stride_i (stride_q),
    .base_i   (base_q),
    .row_o    (win_row),
    .col_o    (win_col),
    .addr_o   (win_addr),
    .last_o   (w_ag_last)
  );

  assign win_valid = (state_q == ST_ISSUE);
  assign win_last  = win_valid & w_ag_last;
  assign sts_busy  = w_busy;
  assign sts_done  = (state_q == ST_DONE);
  assign sts_err   = err_q;
  assign sts_count = count_q;
  assign irq       = irq_q;

endmodule
`default_nettype wire
